// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator family: group state and
// Q-format defaults, plus the accumulator width derivation.
package mac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } grp_state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_FRAC_W  = 14;
  localparam int DEF_GUARD_W = 4;

  // Full product width plus headroom for summing many products.
  function automatic int acc_width(input int data_w, input int guard_w);
    return 2 * data_w + guard_w;
  endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up and saturate from a Q(.)(2*FRAC_W) accumulator
// back to the DATA_W-bit Q(.)FRAC_W input format.
module mac_round_sat #(
  parameter int ACC_W  = 36,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  // One extra bit keeps the rounding bias from wrapping the top of the range.
  localparam logic signed [ACC_W:0] BIAS    = (ACC_W+1)'(1) << (FRAC_W-1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'({(DATA_W-1){1'b1}});
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W:0] w_biased;
  logic signed [ACC_W:0] w_shifted;

  assign w_biased  = {i_acc[ACC_W-1], i_acc} + BIAS;
  assign w_shifted = w_biased >>> FRAC_W;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_sat  = 1'b0;
    o_data = w_shifted[DATA_W-1:0];
    if (w_shifted > SAT_MAX) begin
      o_data = SAT_MAX[DATA_W-1:0];
      o_sat  = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      o_data = SAT_MIN[DATA_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_accum_pipe.sv
// Four-stage signed multiply-accumulate with first/last group framing,
// round/saturate output and overflow/framing status.
module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int FRAC_W  = DEF_FRAC_W,
  parameter  int GUARD_W = DEF_GUARD_W,
  localparam int ACC_W   = acc_width(DATA_W, GUARD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ACC_W-1:0]  acc_out,
  output logic              sat,
  output logic              acc_ovf,
  output logic              frame_err
);

  logic                       r_s1_valid, r_s1_first, r_s1_last;
  logic signed [DATA_W-1:0]   r_s1_a, r_s1_b;
  logic                       r_s2_valid, r_s2_first, r_s2_last;
  logic signed [2*DATA_W-1:0] r_s2_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_ovf;
  logic                       r_s3_valid, r_s3_last, r_s3_ferr;
  grp_state_e                 r_state, w_state_nxt;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_acc_base, w_sum;
  logic                       w_ovf_beat, w_frame_err;
  logic signed [DATA_W-1:0]   w_rs_data;
  logic                       w_rs_sat;

  assign w_prod     = r_s1_a * r_s1_b;
  assign w_prod_ext = ACC_W'(r_s2_prod);
  assign w_acc_base = r_s2_first ? '0 : r_acc;
  assign w_sum      = w_acc_base + w_prod_ext;
  // A first beat loads rather than adds, so it can never wrap.
  assign w_ovf_beat = !r_s2_first && (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1])
                      && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_s2_valid) begin
      if (r_s2_last)       w_state_nxt = IDLE;
      else if (r_s2_first) w_state_nxt = OPEN;
    end
  end

  always_comb begin
    w_frame_err = r_s2_valid && r_s2_first && (r_state == OPEN);
  end

  mac_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .i_acc  (r_acc),
    .o_data (w_rs_data),
    .o_sat  (w_rs_sat)
  );

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of the one before.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well so outputs read 0 after reset, not stale beats.
      r_s1_valid <= 1'b0;  r_s1_first <= 1'b0;  r_s1_last <= 1'b0;
      r_s1_a     <= '0;    r_s1_b     <= '0;
      r_s2_valid <= 1'b0;  r_s2_first <= 1'b0;  r_s2_last <= 1'b0;
      r_s2_prod  <= '0;
      r_acc      <= '0;    r_ovf      <= 1'b0;
      r_s3_valid <= 1'b0;  r_s3_last  <= 1'b0;  r_s3_ferr <= 1'b0;
      out_valid  <= 1'b0;  out_data   <= '0;    acc_out   <= '0;
      sat        <= 1'b0;  acc_ovf    <= 1'b0;  frame_err <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a     <= a_in;
        r_s1_b     <= b_in;
        r_s1_first <= in_first;
        r_s1_last  <= in_last;
      end
      r_s2_valid <= r_s1_valid;
      r_s2_prod  <= w_prod;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      if (r_s2_valid) begin
        r_acc <= w_sum;
        r_ovf <= r_s2_first ? 1'b0 : (r_ovf | w_ovf_beat);
      end
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      r_s3_ferr  <= w_frame_err;
      out_valid  <= r_s3_valid & r_s3_last;
      frame_err  <= r_s3_ferr;
      if (r_s3_valid && r_s3_last) begin
        out_data <= w_rs_data;
        acc_out  <= r_acc;
        sat      <= w_rs_sat;
        acc_ovf  <= r_ovf;
      end
    end
  end

endmodule
